// File: rtl/lsu_pkg.sv
// Shared types, size encodings and helpers for the load/store bus port.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_t;

  typedef enum logic [2:0] {
    LD_B  = 3'd0,
    LD_H  = 3'd1,
    LD_W  = 3'd2,
    LD_BU = 3'd3,
    LD_HU = 3'd4
  } lsu_ld_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_U = 2'b11;

  localparam int LSU_TIMEOUT_DEFAULT = 255;

  // Unsigned loads other than lhu fall back to lbu.
  function automatic lsu_ld_t ld_mode(input logic [1:0] lsz, input logic [2:0] f3);
    case (lsz)
      SZ_B:    ld_mode = LD_B;
      SZ_H:    ld_mode = LD_H;
      SZ_W:    ld_mode = LD_W;
      default: ld_mode = (f3 == 3'b101) ? LD_HU : LD_BU;
    endcase
  endfunction

  function automatic logic [1:0] ld_size(input lsu_ld_t m);
    case (m)
      LD_H, LD_HU: ld_size = SZ_H;
      LD_W:        ld_size = SZ_W;
      default:     ld_size = SZ_B;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = lo[0];
      default: misaligned = (lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_bus_port_lane_align.sv
// Byte-lane steering: store byte enables / write replication and load extraction / extension.
module lsu_bus_port_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  input  logic [2:0]  i_ld_mode,
  input  logic [1:0]  i_rd_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_wdata;
    case (i_size)
      SZ_B: begin
        o_be    = 4'b0001 << i_addr_lo;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SZ_H: begin
        o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata = {2{i_wdata[15:0]}};
      end
      default: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
    endcase
  end

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_rd_lo)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      default: w_byte = i_rdata[31:24];
    endcase
    w_half = i_rd_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  always_comb begin
    o_rdata = i_rdata;
    case (lsu_ld_t'(i_ld_mode))
      LD_B:    o_rdata = {{24{w_byte[7]}}, w_byte};
      LD_H:    o_rdata = {{16{w_half[15]}}, w_half};
      LD_BU:   o_rdata = {24'd0, w_byte};
      LD_HU:   o_rdata = {16'd0, w_half};
      default: o_rdata = i_rdata;
    endcase
  end

endmodule

// File: rtl/lsu_bus_port.sv
// Load/store unit bus port: one word-aligned bus transaction per load/store, core stalled meanwhile.
// Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
//
// state     | meaning
// ST_IDLE   | ready, waiting for req_valid
// ST_REQ    | bus_req high, waiting for bus_gnt
// ST_WAIT_R | load granted, waiting for bus_rvalid
// ST_RESP   | one-cycle rsp_valid pulse
module lsu_bus_port
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_d_wr_en,
  input  logic [1:0]  i_store_size,
  input  logic [1:0]  i_load_size,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_stall,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [3:0]  o_bus_be,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_gnt,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_t  r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        r_we;
  logic [2:0]  r_ld_mode;
  logic [1:0]  r_lo;
  logic [31:0] r_rdata;
  logic        r_err;

  lsu_ld_t     w_ld_mode;
  logic [1:0]  w_size;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_ld_data;
  logic        w_accept;
  logic        w_mis;
  logic        w_tmo;

  assign w_ld_mode = ld_mode(i_load_size, i_funct3);
  assign w_size    = i_d_wr_en ? i_store_size : ld_size(w_ld_mode);
  assign w_accept  = (r_state == ST_IDLE) && i_req_valid;
  assign w_tmo     = (r_cnt == CW'(TIMEOUT_CYCLES - 1));

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_mis = misaligned(w_size, i_addr[1:0]);
`else
  assign w_mis = 1'b0;
`endif

  lsu_bus_port_lane_align u_align (
    .i_size    (w_size),
    .i_addr_lo (i_addr[1:0]),
    .i_wdata   (i_wdata),
    .o_be      (w_be),
    .o_wdata   (w_wdata),
    .i_ld_mode (r_ld_mode),
    .i_rd_lo   (r_lo),
    .i_rdata   (i_bus_rdata),
    .o_rdata   (w_ld_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // A handshake in the expiry cycle takes priority over the timeout.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (i_req_valid) w_next = w_mis ? ST_RESP : ST_REQ;
      ST_REQ: begin
        if (i_bus_gnt)  w_next = r_we ? ST_RESP : ST_WAIT_R;
        else if (w_tmo) w_next = ST_RESP;
      end
      ST_WAIT_R: if (i_bus_rvalid || w_tmo) w_next = ST_RESP;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready = 1'b0;
    o_bus_req   = 1'b0;
    o_rsp_valid = 1'b0;
    o_stall     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_req_ready = 1'b1;
        o_stall     = i_req_valid;
      end
      ST_REQ: begin
        o_bus_req = 1'b1;
        o_stall   = 1'b1;
      end
      ST_WAIT_R: o_stall = 1'b1;
      default:   o_rsp_valid = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_addr    <= '0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_we      <= 1'b0;
      r_ld_mode <= '0;
      r_lo      <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_cnt     <= '0;
          r_addr    <= {i_addr[31:2], 2'b00};
          r_be      <= w_be;
          r_wdata   <= w_wdata;
          r_we      <= i_d_wr_en;
          r_ld_mode <= w_ld_mode;
          r_lo      <= i_addr[1:0];
          r_rdata   <= '0;
          r_err     <= w_mis;
        end
        ST_REQ: begin
          r_cnt <= r_cnt + CW'(1);
          if (!i_bus_gnt && w_tmo) r_err <= 1'b1;
        end
        ST_WAIT_R: begin
          r_cnt <= r_cnt + CW'(1);
          if (i_bus_rvalid) r_rdata <= w_ld_data;
          else if (w_tmo)   r_err   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_bus_we    = r_we;
  assign o_bus_addr  = r_addr;
  assign o_bus_be    = r_be;
  assign o_bus_wdata = r_wdata;
  assign o_rsp_rdata = r_rdata;
  assign o_rsp_err   = r_err;

endmodule
